seven_seg_reader: RTL and testbench
===================================

// Module: seven_seg_reader
// PURPOSE
//  Inverse of the hex->segment path: samples an external 7-segment bus, waits for a stable
//  pattern and encodes it back to a 4-bit hex digit. Each new digit goes out on a valid/ready
//  stream; undecodable patterns are flagged. Used for self-check and loopback of display outputs.
// PARAMETERS
//  STABLE_CYCLES   16   consecutive identical synchronized samples needed to accept a pattern (>=2)
//  SEG_ACTIVE_LOW  1    1: seg_in low = segment lit; 0: high = lit
// PORTS
//  clk        in   1  single clock; all logic on rising edge
//  reset      in   1  asynchronous, active-high reset
//  seg_in     in   7  raw segment bus, async to clk; bit6=a ... bit0=g
//  ready_in   in   1  consumer accepts digit when valid_out && ready_in at a rising edge
//  valid_out  out  1  digit record {hex_out, err_out} is valid
//  hex_out    out  4  decoded digit 0-F (4'h0 when err_out=1)
//  err_out    out  1  accepted pattern is not one of the 16 hex glyphs
// BEHAVIOUR
//  - Reset (async, immediate): valid_out=0, hex_out=0, err_out=0, cnt=0, state=TRACK.
//    Sync flops reset to the raw blank level (7'h7F if SEG_ACTIVE_LOW, else 7'h00).
//    cur, prev and lat_pat reset to BLANK (7'h00, normalized). A pending unaccepted digit is dropped.
//  - Input: 2-flop synchronizer on seg_in, then polarity normalize -> cur (1 = lit).
//  - Stability: prev <= cur every cycle. cnt <= 0 if cur!=prev, else cnt+1, saturating at STABLE_CYCLES.
//    stable = (cur==prev) && (cnt >= STABLE_CYCLES-1). cnt is $clog2(STABLE_CYCLES+1) bits.
//  - Glyphs (normalized, abcdefg): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B
//    A=77 b=1F C=4E d=3D E=4F F=47. BLANK=00. All other 111 codes are invalid.
//  - FSM, 2 states:
//    TRACK: if stable && cur!=lat_pat: lat_pat<=cur.
//           cur==BLANK -> stay TRACK, no output. This arms a repeat of the same digit.
//           else -> HOLD, valid_out<=1; {hex_out,err_out} <= {code,0} for a glyph, else {0,1}.
//    HOLD:  outputs frozen. On valid_out && ready_in -> TRACK, valid_out<=0 at that edge.
//           Synchronizer and stability tracking keep running in HOLD.
//  - Repeated digit: the same glyph is reported again only after a different stable pattern
//    (incl. BLANK) was accepted in between. Glitches shorter than STABLE_CYCLES never report.
//  - Latency: seg_in first sampled at edge k and then held -> valid_out high after edge
//    k+STABLE_CYCLES+2, provided the FSM is in TRACK.
//  - Backpressure: patterns that come and go during HOLD are lost. After the handshake, a
//    pattern that is already stable and differs from lat_pat is reported 1 cycle later
//    (TRACK for one cycle, then HOLD).
//  - valid_out may be high with ready_in already high: the transfer completes at the next edge.
//    No combinational path from ready_in to any output.
// STRUCTURE
//  - seven_seg_pkg: SEG_GLYPH[16] table, SEG_BLANK, typedef enum logic {TRACK, HOLD} reader_state_t.
//  - Sub-module seven_seg_encoder (combinational): pattern[6:0] -> {hit, code[3:0]}, table from pkg.
//  - Top holds synchronizer, stability counter, FSM and output registers. All outputs registered.
// TESTING (STABLE_CYCLES=16, SEG_ACTIVE_LOW=1)
//  1 Reset, seg_in=7'h7F (blank) for 200 cycles -> valid_out stays 0; assert reset mid-HOLD ->
//    valid_out=0 with no clk edge.
//  2 seg_in=7'b000_0110 ('3'), first sampled at edge k, ready_in=1 -> valid_out=1 after
//    edge k+18 for exactly 1 cycle, hex_out=3, err_out=0; no further report while held.
//  3 '3' held 10 cycles then '8' (7'h00) held -> no report of '3'; '8' reported 18 edges after change.
//  4 ready_in=0: 'A' (7'h08) reported, then seg_in -> 'b' (7'h60) for 40 cycles -> hex_out stays A;
//    raise ready_in -> A accepted, b reported 1 cycle later.
//  5 Invalid seg_in=7'b011_0111 (only a+d lit) stable -> valid_out=1, err_out=1, hex_out=0.
//  6 '5' -> blank -> '5' (each 30 cycles) -> two reports of 5; '5' -> 4-cycle '6' glitch -> '5' -> one report.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and glyph table for the 7-segment reader.
// Patterns are normalized to 1 = segment lit, bit6=a ... bit0=g.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Entry i holds the lit-segment pattern of hex digit i.
    localparam logic [15:0][6:0] SEG_GLYPH = {
        7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

    typedef enum logic {
        TRACK = 1'b0,
        HOLD  = 1'b1
    } reader_state_t;

    typedef struct packed {
        logic [3:0] hex;
        logic       err;
    } digit_rec_t;

    function automatic logic [6:0] seg_normalize(input logic [6:0] raw, input bit active_low);
        return active_low ? ~raw : raw;
    endfunction

endpackage

// File: rtl/seven_seg_encoder.sv
// Combinational segment-pattern to hex-digit encoder.
// hit=0 means the pattern is not one of the 16 hex glyphs (code is then 0).
module seven_seg_encoder
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       hit,
    output logic [3:0] code
);

    always_comb begin
        hit  = 1'b0;
        code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_GLYPH[i]) begin
                hit  = 1'b1;
                code = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seven_seg_reader.sv
// Samples an asynchronous 7-segment bus, waits for a stable pattern and reports
// each newly accepted pattern as a hex digit (or error) on a valid/ready stream.
module seven_seg_reader
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_in,
    input  logic       ready_in,
    output logic       valid_out,
    output logic [3:0] hex_out,
    output logic       err_out
);

    localparam int             CW        = $clog2(STABLE_CYCLES + 1);
    localparam logic [6:0]     RAW_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [CW-1:0]  CNT_MAX   = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_THR   = CW'(STABLE_CYCLES - 1);

    logic [6:0]    sync1_q, sync1_d;
    logic [6:0]    sync2_q, sync2_d;
    logic [6:0]    prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    lat_pat_q, lat_pat_d;
    reader_state_t state_q, state_d;
    logic          valid_q, valid_d;
    digit_rec_t    rec_q, rec_d;

    logic [6:0] cur;
    logic       stable;
    logic       accept;
    logic       enc_hit;
    logic [3:0] enc_code;

    assign cur    = seg_normalize(sync2_q, SEG_ACTIVE_LOW);
    assign stable = (cur == prev_q) && (cnt_q >= CNT_THR);
    // A stable pattern is taken only when it differs from the last accepted one,
    // so a held digit reports once and a blank in between re-arms it.
    assign accept = (state_q == TRACK) && stable && (cur != lat_pat_q);

    seven_seg_encoder u_enc (
        .pattern (cur),
        .hit     (enc_hit),
        .code    (enc_code)
    );

    // Synchronizer and stability tracking run in both FSM states.
    always_comb begin
        sync1_d = seg_in;
        sync2_d = sync1_q;
        prev_d  = cur;
        if (cur != prev_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= RAW_BLANK;
            sync2_q <= RAW_BLANK;
            prev_q  <= SEG_BLANK;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TRACK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TRACK: if (accept && (cur != SEG_BLANK)) state_d = HOLD;
            HOLD:  if (valid_q && ready_in)          state_d = TRACK;
            default: state_d = TRACK;
        endcase
    end

    always_comb begin
        valid_d   = valid_q;
        rec_d     = rec_q;
        lat_pat_d = lat_pat_q;
        case (state_q)
            TRACK: begin
                if (accept) begin
                    lat_pat_d = cur;
                    if (cur != SEG_BLANK) begin
                        valid_d   = 1'b1;
                        rec_d.hex = enc_hit ? enc_code : 4'h0;
                        rec_d.err = ~enc_hit;
                    end
                end
            end
            HOLD: begin
                if (valid_q && ready_in) valid_d = 1'b0;
            end
            default: valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            rec_q     <= '0;
            lat_pat_q <= SEG_BLANK;
        end else begin
            valid_q   <= valid_d;
            rec_q     <= rec_d;
            lat_pat_q <= lat_pat_d;
        end
    end

    assign valid_out = valid_q;
    assign hex_out   = rec_q.hex;
    assign err_out   = rec_q.err;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Scoreboard bench for seven_seg_reader: a sample-history reference model predicts
// each report, a negedge monitor compares the DUT stream against it.
module tb_seven_seg_reader;

    localparam int SC = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg_in;
    logic       ready_in;
    logic       valid_out;
    logic [3:0] hex_out;
    logic       err_out;

    int total = 0;
    int bad   = 0;
    int nrep  = 0;

    logic [4:0] exp_q[$];
    logic [6:0] hist[0:SC+1];
    logic       mhold;
    logic [6:0] mlat;

    seven_seg_reader #(.STABLE_CYCLES(SC), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .seg_in    (seg_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .hex_out   (hex_out),
        .err_out   (err_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // {hex, err} for a lit-segment pattern, straight from the glyph list.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h7E: return {4'h0, 1'b0};
            7'h30: return {4'h1, 1'b0};
            7'h6D: return {4'h2, 1'b0};
            7'h79: return {4'h3, 1'b0};
            7'h33: return {4'h4, 1'b0};
            7'h5B: return {4'h5, 1'b0};
            7'h5F: return {4'h6, 1'b0};
            7'h70: return {4'h7, 1'b0};
            7'h7F: return {4'h8, 1'b0};
            7'h7B: return {4'h9, 1'b0};
            7'h77: return {4'hA, 1'b0};
            7'h1F: return {4'hB, 1'b0};
            7'h4E: return {4'hC, 1'b0};
            7'h3D: return {4'hD, 1'b0};
            7'h4F: return {4'hE, 1'b0};
            7'h47: return {4'hF, 1'b0};
            default: return {4'h0, 1'b1};
        endcase
    endfunction

    // Reference model: a pattern counts as stable at an edge when the raw samples
    // taken at the previous SC+1 edges, excluding the latest one, are all equal.
    initial begin
        logic [6:0] cur;
        bit         stable;
        mhold = 1'b0;
        mlat  = 7'h00;
        for (int i = 0; i <= SC + 1; i++) hist[i] = 7'h7F;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int i = 0; i <= SC + 1; i++) hist[i] = 7'h7F;
                mhold = 1'b0;
                mlat  = 7'h00;
                exp_q.delete();
            end else begin
                cur    = ~hist[1];
                stable = 1'b1;
                for (int i = 2; i <= SC + 1; i++) if (hist[i] != hist[1]) stable = 1'b0;
                if (mhold) begin
                    if (ready_in) mhold = 1'b0;
                end else if (stable && cur != mlat) begin
                    mlat = cur;
                    if (cur != 7'h00) begin
                        mhold = 1'b1;
                        exp_q.push_back(decode(cur));
                    end
                end
                for (int i = SC + 1; i >= 1; i--) hist[i] = hist[i-1];
                hist[0] = seg_in;
            end
        end
    end

    // Monitor: a rising valid_out pops one expected record; fields stay frozen while valid.
    initial begin
        logic       pv;
        logic [4:0] cur_exp;
        pv      = 1'b0;
        cur_exp = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 1'b0;
            end else begin
                check("valid", int'(valid_out), int'(mhold));
                if (valid_out && !pv) begin
                    nrep++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_report: got hex=%0h err=%0b expected no report", hex_out, err_out);
                    end else begin
                        cur_exp = exp_q.pop_front();
                    end
                end
                if (valid_out) begin
                    check("hex", int'(hex_out), int'(cur_exp[4:1]));
                    check("err", int'(err_out), int'(cur_exp[0]));
                end
                pv = valid_out;
            end
        end
    end

    task automatic hold(input logic [6:0] raw, input int n);
        seg_in = raw;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int base;
        reset    = 1'b1;
        seg_in   = 7'h7F;
        ready_in = 1'b0;
        #2;
        check("rst_valid", int'(valid_out), 0);
        check("rst_hex", int'(hex_out), 0);
        check("rst_err", int'(err_out), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Blank bus for a long time: nothing reported.
        hold(7'h7F, 200);
        check("blank_reports", nrep, 0);

        // '3' with ready high: one report, none while held.
        ready_in = 1'b1;
        base = nrep;
        hold(7'b000_0110, 60);
        check("three_reports", nrep - base, 1);

        // Short '3' then '8': only '8' is reported.
        hold(7'h7F, 30);
        base = nrep;
        hold(7'b000_0110, 10);
        hold(7'h00, 40);
        check("eight_reports", nrep - base, 1);

        // Backpressure: 'A' held on the stream while 'b' sits on the bus.
        ready_in = 1'b0;
        base = nrep;
        hold(7'h08, 25);
        hold(7'h60, 40);
        check("bp_a_only", nrep - base, 1);
        check("bp_hex_a", int'(hex_out), 4'hA);
        ready_in = 1'b1;
        hold(7'h60, 5);
        check("bp_b_after", nrep - base, 2);

        // Reset while a digit is pending: outputs clear with no clock edge.
        ready_in = 1'b0;
        hold(7'b100_1111, 25);
        check("pre_rst_valid", int'(valid_out), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", int'(valid_out), 0);
        check("async_rst_hex", int'(hex_out), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ready_in = 1'b1;
        hold(7'h7F, 30);

        // Undecodable pattern (a+d lit).
        base = nrep;
        hold(7'b011_0111, 30);
        check("invalid_reports", nrep - base, 1);

        // '5' -> blank -> '5' reports twice; a short '6' glitch inside '5' does not.
        base = nrep;
        hold(7'h24, 30);
        hold(7'h7F, 30);
        hold(7'h24, 30);
        check("five_twice", nrep - base, 2);
        hold(7'h7F, 30);
        base = nrep;
        hold(7'h24, 20);
        hold(7'h20, 4);
        hold(7'h24, 30);
        check("glitch_once", nrep - base, 1);

        // Random patterns, durations and backpressure.
        for (int s = 0; s < 60; s++) begin
            int         r;
            int         n;
            logic [6:0] raw;
            r = $urandom_range(0, 99);
            if (r < 55)      raw = ~decode_glyph($urandom_range(0, 15));
            else if (r < 75) raw = 7'h7F;
            else             raw = 7'($urandom());
            n = $urandom_range(1, 40);
            seg_in = raw;
            repeat (n) begin
                ready_in = ($urandom_range(0, 3) != 0);
                @(posedge clk);
                #1;
            end
        end

        ready_in = 1'b1;
        hold(7'h7F, 40);
        check("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic [6:0] decode_glyph(input int d);
        logic [6:0] g[16];
        g = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        return g[d];
    endfunction

endmodule
